// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: Q4.13 format, arctangent table, func encoding,
// lane indices and the scale stage's gain-compensation table.
package cordic_pkg;

    localparam int INT_WIDTH  = 4;
    localparam int FRAC_WIDTH = 13;
    localparam int DATA_W     = INT_WIDTH + FRAC_WIDTH + 1;
    localparam int ATAN_DEPTH = 14;

    localparam int LANE_X = 2;
    localparam int LANE_Y = 1;
    localparam int LANE_Z = 0;

    typedef logic signed [DATA_W-1:0] q_t;
    typedef logic [3:0]               atan_idx_t;

    typedef enum logic {
        FUNC_ROTATE = 1'b0,
        FUNC_VECTOR = 1'b1
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // round(atan(2^-i) * 2^FRAC_WIDTH)
    function automatic q_t atan_lut(input atan_idx_t idx);
        case (idx)
            4'd0:    return 18'sd6434;
            4'd1:    return 18'sd3798;
            4'd2:    return 18'sd2007;
            4'd3:    return 18'sd1019;
            4'd4:    return 18'sd511;
            4'd5:    return 18'sd256;
            4'd6:    return 18'sd128;
            4'd7:    return 18'sd64;
            4'd8:    return 18'sd32;
            4'd9:    return 18'sd16;
            4'd10:   return 18'sd8;
            4'd11:   return 18'sd4;
            4'd12:   return 18'sd2;
            4'd13:   return 18'sd1;
            default: return '0;
        endcase
    endfunction

    // Inverse CORDIC gain after n micro-rotations, Q4.13; used by the scale stage
    function automatic q_t k_lut(input int n);
        case (n)
            1:       return 18'sd5793;
            2:       return 18'sd5181;
            3:       return 18'sd5026;
            4:       return 18'sd4988;
            5:       return 18'sd4978;
            default: return 18'sd4975;
        endcase
    endfunction

endpackage

// File: rtl/cordic_iter_if.sv
// Operand/result handshake between an upstream producer and the CORDIC engine.
interface cordic_iter_if #(
    parameter int TOTAL_OP_WIDTH = 55
);
    logic                      i_vld;
    logic                      o_rdy;
    logic [TOTAL_OP_WIDTH-1:0] i_data;
    logic                      o_vld;
    logic [TOTAL_OP_WIDTH-1:0] o_data;

    modport master (output i_vld, output i_data, input o_rdy, input o_vld, input o_data);
    modport slave  (input i_vld, input i_data, output o_rdy, output o_vld, output o_data);
endinterface

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation; direction chosen from z (rotate)
// or y (vector).
module cordic_microrot
    import cordic_pkg::*;
(
    input  q_t        x_in,
    input  q_t        y_in,
    input  q_t        z_in,
    input  atan_idx_t shift,
    input  logic      mode,
    output q_t        x_out,
    output q_t        y_out,
    output q_t        z_out
);
    logic d_pos;
    q_t   x_sh;
    q_t   y_sh;
    q_t   atan;

    always_comb begin
        d_pos = (mode == FUNC_VECTOR) ? y_in[DATA_W-1] : ~z_in[DATA_W-1];
        x_sh  = x_in >>> shift;
        y_sh  = y_in >>> shift;
        atan  = atan_lut(shift);
        if (d_pos) begin
            x_out = x_in - y_sh;
            y_out = y_in + x_sh;
            z_out = z_in - atan;
        end else begin
            x_out = x_in + y_sh;
            y_out = y_in - x_sh;
            z_out = z_in + atan;
        end
    end
endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, unscaled result
// presented as a one-cycle strobe in the scale stage's packed format.
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int NUM_ITER       = 12,
    parameter int NUM_DATA       = 3,
    parameter int FUNC_WIDTH     = 1,
    parameter int DATA_OP_WIDTH  = 18,
    parameter int TOTAL_OP_WIDTH = NUM_DATA*DATA_OP_WIDTH+FUNC_WIDTH
)(
    input logic           i_clk,
    input logic           i_rst,
    cordic_iter_if.slave  bus
);
    localparam atan_idx_t LAST_ITER = atan_idx_t'(NUM_ITER-1);

    state_e                    state_q, state_d;
    atan_idx_t                 cnt_q, cnt_d;
    q_t                        x_q, x_d, y_q, y_d, z_q, z_d;
    logic [FUNC_WIDTH-1:0]     func_q, func_d;
    logic [TOTAL_OP_WIDTH-1:0] odata_q, odata_d;
    q_t                        x_n, y_n, z_n;
    logic                      rdy;
    logic                      accept;

    cordic_microrot u_microrot (
        .x_in  (x_q),
        .y_in  (y_q),
        .z_in  (z_q),
        .shift (cnt_q),
        .mode  (func_q[0]),
        .x_out (x_n),
        .y_out (y_n),
        .z_out (z_n)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        func_d  = func_q;
        odata_d = odata_q;
        rdy     = (state_q != ST_RUN);
        accept  = bus.i_vld && rdy;
        case (state_q)
            ST_RUN: begin
                x_d   = x_n;
                y_d   = y_n;
                z_d   = z_n;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                    odata_d = {func_q, x_n, y_n, z_n};
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE when nothing arrives
                if (accept) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    x_d     = bus.i_data[LANE_X*DATA_OP_WIDTH +: DATA_OP_WIDTH];
                    y_d     = bus.i_data[LANE_Y*DATA_OP_WIDTH +: DATA_OP_WIDTH];
                    z_d     = bus.i_data[LANE_Z*DATA_OP_WIDTH +: DATA_OP_WIDTH];
                    func_d  = bus.i_data[TOTAL_OP_WIDTH-1 -: FUNC_WIDTH];
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            func_q  <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            func_q  <= func_d;
            odata_q <= odata_d;
        end
    end

    assign bus.o_rdy  = rdy;
    assign bus.o_vld  = (state_q == ST_DONE);
    assign bus.o_data = odata_q;
endmodule
